// File: rtl/ysyx_22050039_lsu.sv
// ysyx_22050039_lsu -- multi-cycle load/store unit between execute and writeback.
//
// Accepts one request at a time from execute. It issues the request on an
// 8-byte-aligned valid/ready memory port and waits for the memory completion.
// It then returns either an extended load result or a store completion to
// writeback. Misaligned requests never reach memory. They come back at once
// with resp_err set.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   req_*             execute-side request (valid/ready, wen, addr, wdata,
//                     size, unsigned)
//   resp_*            writeback-side response (valid/ready, rdata, err)
//   mem_req_*         memory request (valid/ready, wen, addr, wdata, wmask)
//   mem_rvalid/rdata  memory completion: read data or write ack
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; latch it and check alignment
// REQ   | memory request presented, held until mem_req_ready
// WAIT  | request accepted by memory, waiting for mem_rvalid
// RESP  | result presented to writeback, held until resp_ready

module ysyx_22050039_lsu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            wen_q, wen_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [2:0]      off;
  logic [7:0]      size_mask;
  logic            misaligned;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;
  logic            sx;

  assign off = addr_q[2:0];

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      2'd3:    misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    size_mask = 8'h01;
    case (size_q)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted  = mem_rdata >> {off, 3'b000};
    sx       = ~uns_q;
    load_ext = shifted;
    case (size_q)
      2'd0:    load_ext = {{56{sx & shifted[7]}},  shifted[7:0]};
      2'd1:    load_ext = {{48{sx & shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = {{32{sx & shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wen_d   = wen_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wen_d   = req_wen;
          rdata_d = '0;
          err_d   = misaligned;
          state_d = misaligned ? RESP : REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        // mem_rvalid is only honoured here, so stray completions elsewhere drop.
        if (mem_rvalid) begin
          rdata_d = wen_q ? '0 : load_ext;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wen_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wen_q   <= wen_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Every output comes from state and latched fields only.
  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign mem_wen       = (state_q == REQ) & wen_q;
  assign mem_addr      = {addr_q[XLEN-1:3], 3'b000};
  assign mem_wdata     = wdata_q << {off, 3'b000};
  assign mem_wmask     = wen_q ? (size_mask << off) : 8'h00;

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
module tb_ysyx_22050039_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22050039_lsu #(.XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] rdata;
    int          d_req;
    int          d_rv;
    int          d_resp;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic [63:0] exp_addr;
    logic [7:0]  exp_wmask;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, built byte by byte from the access rules.
  function automatic logic model_misaligned(input logic [63:0] addr, input logic [1:0] size);
    int nb = 1 << size;
    return (addr % nb) != 0;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input logic [1:0] size, input logic uns);
    int nb = 1 << size;
    int off = int'(addr % 8);
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++) v[i*8 +: 8] = rdata[(off+i)*8 +: 8];
    if (!uns && nb < 8 && v[nb*8-1])
      for (int i = nb; i < 8; i++) v[i*8 +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [63:0] addr, input logic [1:0] size);
    int nb = 1 << size;
    int off = int'(addr % 8);
    logic [7:0] m = '0;
    for (int j = 0; j < 8; j++) m[j] = (j >= off) && (j < off + nb);
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wdata, input logic [63:0] addr);
    int off = int'(addr % 8);
    logic [63:0] d = '0;
    for (int j = 0; j < 8; j++) if (j >= off) d[j*8 +: 8] = wdata[(j-off)*8 +: 8];
    return d;
  endfunction

  function automatic vec_t mk(input string name, input logic wen, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [1:0] size, input logic uns,
                              input logic [63:0] rdata, input int d_req, input int d_rv,
                              input int d_resp, input logic [63:0] exp_rdata, input logic exp_err,
                              input logic [63:0] exp_addr, input logic [7:0] exp_wmask,
                              input logic [63:0] exp_wdata);
    vec_t v;
    v.name = name; v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.rdata = rdata; v.d_req = d_req; v.d_rv = d_rv; v.d_resp = d_resp;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_addr = exp_addr;
    v.exp_wmask = exp_wmask; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk({v.name, ".req_ready_idle"}, {63'd0, req_ready}, 64'd1);
    req_valid    = 1'b1;
    req_wen      = v.wen;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_size     = v.size;
    req_unsigned = v.uns;
    @(negedge clk);
    // Scramble request inputs so any combinational leak shows up.
    req_valid    = 1'b0;
    req_wen      = ~v.wen;
    req_addr     = {$urandom, $urandom};
    req_wdata    = {$urandom, $urandom};
    req_size     = 2'($urandom);
    req_unsigned = ~v.uns;
    if (!v.exp_err) begin
      for (int k = 0; k <= v.d_req; k++) begin
        chk({v.name, ".mem_req_valid"}, {63'd0, mem_req_valid}, 64'd1);
        chk({v.name, ".mem_wen"},       {63'd0, mem_wen}, {63'd0, v.wen});
        chk({v.name, ".mem_addr"},      mem_addr, v.exp_addr);
        chk({v.name, ".mem_wmask"},     {56'd0, mem_wmask}, {56'd0, v.exp_wmask});
        if (v.wen) chk({v.name, ".mem_wdata"}, mem_wdata, v.exp_wdata);
        chk({v.name, ".req_ready_req"}, {63'd0, req_ready}, 64'd0);
        chk({v.name, ".resp_valid_req"}, {63'd0, resp_valid}, 64'd0);
        if (k == v.d_req) mem_req_ready = 1'b1;
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      for (int k = 0; k <= v.d_rv; k++) begin
        chk({v.name, ".mem_req_valid_wait"}, {63'd0, mem_req_valid}, 64'd0);
        chk({v.name, ".req_ready_wait"},     {63'd0, req_ready}, 64'd0);
        chk({v.name, ".resp_valid_wait"},    {63'd0, resp_valid}, 64'd0);
        if (k == v.d_rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
        end
        @(negedge clk);
      end
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
    end
    for (int k = 0; k <= v.d_resp; k++) begin
      chk({v.name, ".resp_valid"},         {63'd0, resp_valid}, 64'd1);
      chk({v.name, ".resp_rdata"},         resp_rdata, v.exp_rdata);
      chk({v.name, ".resp_err"},           {63'd0, resp_err}, {63'd0, v.exp_err});
      chk({v.name, ".req_ready_resp"},     {63'd0, req_ready}, 64'd0);
      chk({v.name, ".mem_req_valid_resp"}, {63'd0, mem_req_valid}, 64'd0);
      if (k == v.d_resp) resp_ready = 1'b1;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    chk({v.name, ".resp_valid_done"}, {63'd0, resp_valid}, 64'd0);
    chk({v.name, ".resp_err_done"},   {63'd0, resp_err}, 64'd0);
    chk({v.name, ".req_ready_done"},  {63'd0, req_ready}, 64'd1);
  endtask

  function automatic vec_t rand_vec(input int idx);
    vec_t v;
    int nb;
    int off;
    v.name   = $sformatf("rnd%0d", idx);
    v.wen    = 1'($urandom);
    v.size   = 2'($urandom);
    v.uns    = 1'($urandom);
    nb       = 1 << v.size;
    off      = $urandom_range(0, 7);
    if ($urandom_range(0, 3) != 0) off = off - (off % nb);
    v.addr   = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 8 + 64'(off);
    v.wdata  = {$urandom, $urandom};
    v.rdata  = {$urandom, $urandom};
    v.d_req  = $urandom_range(0, 3);
    v.d_rv   = $urandom_range(0, 3);
    v.d_resp = $urandom_range(0, 2);
    v.exp_err   = model_misaligned(v.addr, v.size);
    v.exp_rdata = (v.exp_err || v.wen) ? 64'd0 : model_load(v.rdata, v.addr, v.size, v.uns);
    v.exp_addr  = v.addr - (v.addr % 8);
    v.exp_wmask = v.wen ? model_wmask(v.addr, v.size) : 8'h00;
    v.exp_wdata = model_wdata(v.wdata, v.addr);
    return v;
  endfunction

  initial begin
    rst = 1'b0;
    req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_size = '0; req_unsigned = 0;
    resp_ready = 0; mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0;

    vecs.push_back(mk("lw", 0, 64'h8000_0004, 64'h0, 2'd2, 0, 64'h8765_4321_1234_5678, 0, 0, 0,
                      64'hFFFF_FFFF_8765_4321, 0, 64'h8000_0000, 8'h00, 64'h0));
    vecs.push_back(mk("lb", 0, 64'h8000_0003, 64'h0, 2'd0, 0, 64'h0000_0000_F200_0000, 0, 0, 0,
                      64'hFFFF_FFFF_FFFF_FFF2, 0, 64'h8000_0000, 8'h00, 64'h0));
    vecs.push_back(mk("lbu", 0, 64'h8000_0003, 64'h0, 2'd0, 1, 64'h0000_0000_F200_0000, 0, 0, 0,
                      64'h0000_0000_0000_00F2, 0, 64'h8000_0000, 8'h00, 64'h0));
    vecs.push_back(mk("sh", 1, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 2'd1, 0, 64'h0, 0, 0, 0,
                      64'h0, 0, 64'h8000_0000, 8'hC0, 64'hABCD_0000_0000_0000));
    vecs.push_back(mk("misal", 0, 64'h8000_0002, 64'h0, 2'd3, 0, 64'h0, 0, 0, 0,
                      64'h0, 1, 64'h0, 8'h00, 64'h0));
    vecs.push_back(mk("bp_ld", 0, 64'h8000_0010, 64'h0, 2'd3, 1, 64'h0123_4567_89AB_CDEF, 4, 3, 2,
                      64'h0123_4567_89AB_CDEF, 0, 64'h8000_0010, 8'h00, 64'h0));
    vecs.push_back(mk("bp_sw", 1, 64'h8000_001C, 64'hDEAD_BEEF_CAFE_F00D, 2'd2, 0, 64'h0, 4, 3, 2,
                      64'h0, 0, 64'h8000_0018, 8'hF0, 64'hCAFE_F00D_0000_0000));
    vecs.push_back(mk("lhu", 0, 64'h8000_0002, 64'h0, 2'd1, 1, 64'h0000_0000_8001_0000, 0, 1, 0,
                      64'h0000_0000_0000_8001, 0, 64'h8000_0000, 8'h00, 64'h0));
    vecs.push_back(mk("misal_h", 1, 64'h8000_0005, 64'h1234, 2'd1, 0, 64'h0, 0, 0, 1,
                      64'h0, 1, 64'h0, 8'h00, 64'h0));

    repeat (3) @(negedge clk);
    chk("rst.req_ready",     {63'd0, req_ready}, 64'd1);
    chk("rst.resp_valid",    {63'd0, resp_valid}, 64'd0);
    chk("rst.mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst.mem_addr",      mem_addr, 64'd0);
    chk("rst.mem_wmask",     {56'd0, mem_wmask}, 64'd0);
    chk("rst.resp_rdata",    resp_rdata, 64'd0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting on memory, followed by a stray completion.
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_addr = 64'h8000_0008; req_size = 2'd3; req_unsigned = 0;
    @(negedge clk);
    req_valid = 0;
    chk("rstw.mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    chk("rstw.in_wait", {63'd0, mem_req_valid}, 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("rstw.req_ready",     {63'd0, req_ready}, 64'd1);
    chk("rstw.resp_valid",    {63'd0, resp_valid}, 64'd0);
    chk("rstw.mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rstw.mem_addr",      mem_addr, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    mem_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("rstw.stray_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rstw.stray_req_ready",  {63'd0, req_ready}, 64'd1);
      chk("rstw.stray_rdata",      resp_rdata, 64'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 60; i++) run_vec(rand_vec(i));

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
